fxp_mul_seq: RTL and testbench

FXP_MUL_SEQ -- requirements
Module: fxp_mul_seq

---
 rtl/fxp_pkg.sv | 7 +
 rtl/fxp_mul_seq.sv | 72 +++++++
 tb/tb_fxp_mul_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// fxp_pkg: default fixed-point widths and FSM states shared by the divider and multiplier blocks.
package fxp_pkg;
  localparam int Q_I_W_DEF = 4;
  localparam int Q_F_W_DEF = 8;
  localparam int B_W_DEF   = 9;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fxp_mul_seq.sv
// fxp_mul_seq: sequential shift-add multiply of fixed-point q by integer b, o = (q*b) >> Q_F_W.
// Define FXP_MUL_ROUND_EN to round half up instead of truncating.
module fxp_mul_seq
  import fxp_pkg::*;
#(
  parameter int Q_I_W = Q_I_W_DEF,
  parameter int Q_F_W = Q_F_W_DEF,
  parameter int B_W   = B_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Q_I_W+Q_F_W-1:0] q,
  input  logic [B_W-1:0]       b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Q_I_W+B_W-1:0] o
);
  localparam int Q_W = Q_I_W + Q_F_W;
  localparam int P_W = Q_W + B_W;
  localparam int O_W = Q_I_W + B_W;
  localparam int C_W = $clog2(B_W + 1);
  state_t         state;
  logic [P_W-1:0] mc, acc, acc_nxt, res;
  logic [B_W-1:0] mr;
  logic [C_W-1:0] cnt;
  logic           last;
  assign acc_nxt   = mr[0] ? acc + mc : acc;
  assign last      = cnt == C_W'(B_W - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
`ifdef FXP_MUL_ROUND_EN
  localparam logic [P_W-1:0] HALF = P_W'(1) << (Q_F_W - 1);
  assign res = acc_nxt + HALF;
`else
  assign res = acc_nxt;
`endif
  // The final iteration writes o straight from the next accumulator value, so DONE follows the B_W-th RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mc    <= '0;
      mr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      o     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mc    <= P_W'(q);
          mr    <= b;
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          mc  <= mc << 1;
          mr  <= mr >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            o     <= res[P_W-1:Q_F_W];
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_mul_seq.sv
// tb_fxp_mul_seq: vector table, stall/reset corner cases and randomized stream against an arithmetic model.
module tb_fxp_mul_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [11:0] q = '0;
  logic [8:0]  b = '0;
  logic        in_ready, out_valid;
  logic [12:0] o;
  int checks = 0, failures = 0;

  fxp_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .b(b), .out_valid(out_valid), .out_ready(out_ready), .o(o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [11:0] q;
    logic [8:0]  b;
    int          tr;
    int          rd;
  } vec_t;
  vec_t v[8];

  function automatic longint model(input longint qv, input longint bv);
`ifdef FXP_MUL_ROUND_EN
    return (qv * bv + 128) / 256;
`else
    return (qv * bv) / 256;
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start(input logic [11:0] qv, input logic [8:0] bv);
    @(negedge clk);
    in_valid = 1; q = qv; b = bv; out_ready = 0;
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  // Returns edges counted from the accepting edge (inclusive) until out_valid is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      q = 12'($urandom); b = 9'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 0;
  endtask

  task automatic txn(input logic [11:0] qv, input logic [8:0] bv, input longint ex, input string nm);
    int n;
    start(qv, bv);
    wait_done(n);
    chk({nm, "_lat"}, n, 10);
    chk({nm, "_o"}, o, ex);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int n, bad, pushed, recvd, cyc;
    longint exq[$];
    longint e;
    v[0] = '{12'h180, 9'd10, 15, 15};
    v[1] = '{12'h080, 9'd5, 2, 3};
    v[2] = '{12'hFFF, 9'd511, 8174, 8174};
    v[3] = '{12'h123, 9'd0, 0, 0};
    v[4] = '{12'h000, 9'd511, 0, 0};
    v[5] = '{12'h100, 9'd1, 1, 1};
    v[6] = '{12'h0C0, 9'd1, 0, 1};
    v[7] = '{12'h001, 9'd511, 1, 2};

    #23;
    chk("rst_o", o, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
`ifdef FXP_MUL_ROUND_EN
      txn(v[i].q, v[i].b, v[i].rd, $sformatf("vec%0d", i));
`else
      txn(v[i].q, v[i].b, v[i].tr, $sformatf("vec%0d", i));
`endif
    end

    // Stall in DONE for 20 cycles with out_ready low.
    start(12'h180, 9'd10);
    wait_done(n);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom); q = 12'($urandom); b = 9'($urandom);
      @(negedge clk);
      if (o !== 13'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 0;
    chk("stall_stable_bad_cycles", bad, 0);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("stall_release_idle", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of RUN.
    start(12'hFFF, 9'd511);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #2;
    chk("abort_o_during_rst", o, 0);
    @(negedge clk);
    rst_n = 1;
    chk("abort_ready", in_ready, 1);
    chk("abort_o", o, 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("abort_no_stale_valid", bad, 0);

    // Randomized stream: in_valid held high, out_ready random, q/b change every cycle.
    pushed = 0; recvd = 0; cyc = 0;
    while (recvd < 40 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      q = 12'($urandom); b = 9'($urandom);
      out_ready = 1'($urandom);
      in_valid = pushed < 40;
      if (in_valid && in_ready) begin
        exq.push_back(model(q, b));
        pushed++;
      end
      if (out_valid && out_ready) begin
        if (exq.size() == 0) chk("stream_dup", 1, 0);
        else begin
          e = exq.pop_front();
          chk($sformatf("stream%0d", recvd), o, e);
        end
        recvd++;
      end
    end
    in_valid = 0; out_ready = 0;
    chk("stream_recvd", recvd, 40);
    chk("stream_left", exq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
